updown_decoder: RTL and testbench

UPDOWN_DECODER -- requirements
Module: updown_decoder

---
 rtl/updown_decoder_pkg.sv | 20 ++
 rtl/updown_step_classify.sv | 30 +++
 rtl/updown_decoder.sv | 125 ++++++++++++
 tb/tb_updown_decoder.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/updown_decoder_pkg.sv
// Shared types and constants for the up/down counter decoder.
package updown_decoder_pkg;

    localparam int unsigned CountW = 3;

    typedef enum logic [1:0] {
        StPrime = 2'd0,
        StUp    = 2'd1,
        StDown  = 2'd2,
        StErr   = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        ClsHold = 2'd0,
        ClsUp   = 2'd1,
        ClsDown = 2'd2,
        ClsJump = 2'd3
    } step_cls_e;

endpackage

// File: rtl/updown_step_classify.sv
// Classifies a new counter sample against the previous one (modulo 8).
module updown_step_classify
    import updown_decoder_pkg::*;
(
    input  logic [CountW-1:0] prev,
    input  logic [CountW-1:0] q,
    output step_cls_e         cls,
    output logic              wrap
);

    logic [CountW-1:0] prev_inc;
    logic [CountW-1:0] prev_dec;

    always_comb begin
        prev_inc = prev + CountW'(1);
        prev_dec = prev - CountW'(1);
        cls      = ClsJump;
        if (q == prev) begin
            cls = ClsHold;
        end else if (q == prev_inc) begin
            cls = ClsUp;
        end else if (q == prev_dec) begin
            cls = ClsDown;
        end
    end

    // Only meaningful alongside an up or down classification.
    assign wrap = ((prev == '1) && (q == '0)) || ((prev == '0) && (q == '1));

endmodule

// File: rtl/updown_decoder.sv
// Tracks an observed 3-bit up/down counter, recovering a wider position,
// direction, reversal and wrap events, with a sticky error on illegal jumps.
module updown_decoder
    import updown_decoder_pkg::*;
#(
    parameter int unsigned POS_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [CountW-1:0] q,
    input  logic              clr_err,
    output logic              step,
    output logic              dir,
    output logic              rev,
    output logic              wrap,
    output logic [POS_W-1:0]  pos,
    output logic              err,
    output logic [1:0]        state
);

    state_e            state_q, state_d;
    logic [CountW-1:0] prev_q, prev_d;
    logic [POS_W-1:0]  pos_q, pos_d;
    logic              dir_q, dir_d;
    logic              err_q, err_d;
    logic              step_q, step_d;
    logic              rev_q, rev_d;
    logic              wrap_q, wrap_d;

    step_cls_e cls;
    logic      cls_wrap;

    updown_step_classify u_classify (
        .prev (prev_q),
        .q    (q),
        .cls  (cls),
        .wrap (cls_wrap)
    );

    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        pos_d   = pos_q;
        dir_d   = dir_q;
        err_d   = err_q;
        step_d  = 1'b0;
        rev_d   = 1'b0;
        wrap_d  = 1'b0;

        if (clr_err) begin
            err_d   = 1'b0;
            state_d = StPrime;
        end else if (en) begin
            unique case (state_q)
                StPrime: begin
                    prev_d  = q;
                    pos_d   = POS_W'(q);
                    state_d = StUp;
                end
                StUp, StDown: begin
                    unique case (cls)
                        ClsUp: begin
                            pos_d   = pos_q + POS_W'(1);
                            dir_d   = 1'b1;
                            step_d  = 1'b1;
                            rev_d   = (state_q == StDown);
                            wrap_d  = cls_wrap;
                            prev_d  = q;
                            state_d = StUp;
                        end
                        ClsDown: begin
                            pos_d   = pos_q - POS_W'(1);
                            dir_d   = 1'b0;
                            step_d  = 1'b1;
                            rev_d   = (state_q == StUp);
                            wrap_d  = cls_wrap;
                            prev_d  = q;
                            state_d = StDown;
                        end
                        ClsJump: begin
                            err_d   = 1'b1;
                            state_d = StErr;
                        end
                        default: ;
                    endcase
                end
                // Samples are ignored until clr_err re-primes.
                StErr: ;
                default: state_d = StPrime;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StPrime;
            prev_q  <= '0;
            pos_q   <= '0;
            dir_q   <= 1'b1;
            err_q   <= 1'b0;
            step_q  <= 1'b0;
            rev_q   <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            pos_q   <= pos_d;
            dir_q   <= dir_d;
            err_q   <= err_d;
            step_q  <= step_d;
            rev_q   <= rev_d;
            wrap_q  <= wrap_d;
        end
    end

    assign step  = step_q;
    assign dir   = dir_q;
    assign rev   = rev_q;
    assign wrap  = wrap_q;
    assign pos   = pos_q;
    assign err   = err_q;
    assign state = state_q;

endmodule

// File: tb/tb_updown_decoder.sv
// Directed, table-driven bench for updown_decoder (POS_W = 8).
module tb_updown_decoder;

    typedef struct {
        logic       en;
        logic       clr;
        logic [2:0] q;
        logic [14:0] exp;  // {step, dir, rev, wrap, pos[7:0], err, state[1:0]}
    } vec_t;

    localparam int NumVec = 30;

    logic       clk;
    logic       reset;
    logic       en;
    logic [2:0] q;
    logic       clr_err;
    logic       step;
    logic       dir;
    logic       rev;
    logic       wrap;
    logic [7:0] pos;
    logic       err;
    logic [1:0] state;

    int n_vec;
    int n_fail;
    vec_t vecs[NumVec];

    updown_decoder #(.POS_W(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .q       (q),
        .clr_err (clr_err),
        .step    (step),
        .dir     (dir),
        .rev     (rev),
        .wrap    (wrap),
        .pos     (pos),
        .err     (err),
        .state   (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input int e, input int c, input int qq, input int s,
                                input int d, input int r, input int w, input int p,
                                input int er, input int st);
        vec_t v;
        v.en  = 1'(e);
        v.clr = 1'(c);
        v.q   = 3'(qq);
        v.exp = {1'(s), 1'(d), 1'(r), 1'(w), 8'(p), 1'(er), 2'(st)};
        return v;
    endfunction

    function automatic logic [14:0] expv(input int s, input int d, input int r, input int w,
                                         input int p, input int er, input int st);
        return {1'(s), 1'(d), 1'(r), 1'(w), 8'(p), 1'(er), 2'(st)};
    endfunction

    task automatic check(input string name, input logic [14:0] exp);
        logic [14:0] act;
        act = {step, dir, rev, wrap, pos, err, state};
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got step=%b dir=%b rev=%b wrap=%b pos=%0d err=%b state=%0d, expected step=%b dir=%b rev=%b wrap=%b pos=%0d err=%b state=%0d",
                     name, act[14], act[13], act[12], act[11], act[10:3], act[2], act[1:0],
                     exp[14], exp[13], exp[12], exp[11], exp[10:3], exp[2], exp[1:0]);
        end
    endtask

    task automatic apply(input logic e, input logic c, input logic [2:0] qq);
        en      = e;
        clr_err = c;
        q       = qq;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec  = 0;
        n_fail = 0;

        // en, clr, q -> step, dir, rev, wrap, pos, err, state
        vecs[0]  = mk(1, 0, 3, 0, 1, 0, 0,   3, 0, 1);
        vecs[1]  = mk(1, 0, 4, 1, 1, 0, 0,   4, 0, 1);
        vecs[2]  = mk(1, 0, 5, 1, 1, 0, 0,   5, 0, 1);
        vecs[3]  = mk(1, 0, 6, 1, 1, 0, 0,   6, 0, 1);
        vecs[4]  = mk(1, 0, 7, 1, 1, 0, 0,   7, 0, 1);
        vecs[5]  = mk(1, 0, 0, 1, 1, 0, 1,   8, 0, 1);
        vecs[6]  = mk(0, 1, 0, 0, 1, 0, 0,   8, 0, 0);
        vecs[7]  = mk(1, 0, 2, 0, 1, 0, 0,   2, 0, 1);
        vecs[8]  = mk(1, 0, 3, 1, 1, 0, 0,   3, 0, 1);
        vecs[9]  = mk(1, 0, 4, 1, 1, 0, 0,   4, 0, 1);
        vecs[10] = mk(1, 0, 3, 1, 0, 1, 0,   3, 0, 2);
        vecs[11] = mk(1, 0, 2, 1, 0, 0, 0,   2, 0, 2);
        vecs[12] = mk(0, 1, 0, 0, 0, 0, 0,   2, 0, 0);
        vecs[13] = mk(1, 0, 5, 0, 0, 0, 0,   5, 0, 1);
        vecs[14] = mk(1, 0, 5, 0, 0, 0, 0,   5, 0, 1);
        vecs[15] = mk(0, 0, 5, 0, 0, 0, 0,   5, 0, 1);
        vecs[16] = mk(1, 0, 5, 0, 0, 0, 0,   5, 0, 1);
        vecs[17] = mk(0, 0, 5, 0, 0, 0, 0,   5, 0, 1);
        vecs[18] = mk(0, 0, 6, 0, 0, 0, 0,   5, 0, 1);
        vecs[19] = mk(0, 1, 0, 0, 0, 0, 0,   5, 0, 0);
        vecs[20] = mk(1, 0, 1, 0, 0, 0, 0,   1, 0, 1);
        vecs[21] = mk(1, 0, 4, 0, 0, 0, 0,   1, 1, 3);
        vecs[22] = mk(1, 0, 5, 0, 0, 0, 0,   1, 1, 3);
        vecs[23] = mk(1, 1, 6, 0, 0, 0, 0,   1, 0, 0);
        vecs[24] = mk(1, 0, 6, 0, 0, 0, 0,   6, 0, 1);
        vecs[25] = mk(0, 1, 0, 0, 0, 0, 0,   6, 0, 0);
        vecs[26] = mk(1, 0, 0, 0, 0, 0, 0,   0, 0, 1);
        vecs[27] = mk(1, 0, 7, 1, 0, 1, 1, 255, 0, 2);
        vecs[28] = mk(1, 0, 0, 1, 1, 1, 1,   0, 0, 1);
        vecs[29] = mk(1, 0, 0, 0, 1, 0, 0,   0, 0, 1);

        reset   = 1'b0;
        en      = 1'b0;
        clr_err = 1'b0;
        q       = 3'd0;
        #12;
        check("reset_values", expv(0, 1, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        reset = 1'b1;

        for (int i = 0; i < NumVec; i++) begin
            apply(vecs[i].en, vecs[i].clr, vecs[i].q);
            check($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Async reset mid-cycle while a step pulse is high.
        apply(1'b1, 1'b0, 3'd1);
        check("pre_reset_step", expv(1, 1, 0, 0, 1, 0, 1));
        #2;
        reset = 1'b0;
        #1;
        check("async_reset", expv(0, 1, 0, 0, 0, 0, 0));
        #3;
        reset = 1'b1;
        apply(1'b1, 1'b0, 3'd6);
        check("reprime_after_reset", expv(0, 1, 0, 0, 6, 0, 1));
        apply(1'b1, 1'b0, 3'd5);
        check("step_after_reprime", expv(1, 0, 1, 0, 5, 0, 2));
        apply(1'b1, 1'b0, 3'd3);
        check("jump_from_down", expv(0, 0, 0, 0, 5, 1, 3));
        apply(1'b0, 1'b0, 3'd3);
        check("err_sticky", expv(0, 0, 0, 0, 5, 1, 3));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
